// File: rtl/clk_en_div_mc.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_div_mc
// Brief    : Multi-channel programmable clock-enable strobe generator with
//            boundary-aligned divisor updates and global realign.
// Revision : 1.0 - initial release
// ============================================================================
module clk_en_div_mc #(
    parameter  int NUM_CH      = 2,
    parameter  int DIV_W       = 8,
    parameter  int DEFAULT_DIV = 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [DIV_W-1:0] C_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] C_ONE         = DIV_W'(1);

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_wr;
    logic              w_sel_pend;
    logic [DIV_W-1:0]  w_cfg_div;

    // Out-of-range channel indices match nothing, so they read as not pending
    // and are accepted without touching any channel.
    always_comb begin
        w_sel_pend = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_sel_pend = w_pend[i];
            end
        end
    end

    assign cfg_ready = !sync && !w_sel_pend;
    assign w_cfg_div = (cfg_div == '0) ? C_ONE : cfg_div;
    assign pend      = w_pend;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_div_cur;
        logic [DIV_W-1:0] r_div_pend;
        logic             r_pend;
        logic             r_tick;
        logic             w_wrap;

        assign w_wrap    = (r_cnt == (r_div_cur - C_ONE));
        assign w_wr[i]   = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        assign w_pend[i] = r_pend;
        assign tick[i]   = r_tick;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt      <= '0;
                r_div_cur  <= C_DEFAULT_DIV;
                r_div_pend <= C_DEFAULT_DIV;
                r_pend     <= 1'b0;
                r_tick     <= 1'b0;
            end else if (sync) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
                if (r_pend) begin
                    r_div_cur <= r_div_pend;
                    r_pend    <= 1'b0;
                end
            end else begin
                if (en) begin
                    if (w_wrap) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                        if (r_pend) begin
                            r_div_cur <= r_div_pend;
                            r_pend    <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt + C_ONE;
                        r_tick <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                end
                // A write is only possible while r_pend is clear, so it never
                // collides with the apply above.
                if (w_wr[i]) begin
                    r_div_pend <= w_cfg_div;
                    r_pend     <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_en_div_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_en_div_mc
// Brief    : Scoreboard bench: expected tick events queued, monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_en_div_mc;

    logic       clk = 1'b0;
    logic       reset, en, sync;
    logic       cfg_valid, cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [1:0] tick, pend;

    logic       cfg3_valid, cfg3_ready;
    logic [1:0] cfg3_ch;
    logic [7:0] cfg3_div;
    logic [2:0] tick3, pend3;

    always #5 clk = ~clk;

    clk_en_div_mc #(.NUM_CH(2), .DIV_W(8), .DEFAULT_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .tick(tick), .pend(pend)
    );

    clk_en_div_mc #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(4)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready), .cfg_ch(cfg3_ch),
        .cfg_div(cfg3_div), .tick(tick3), .pend(pend3)
    );

    typedef struct {
        int         cyc;
        logic [1:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   base   = 0;
    logic mon_on = 1'b0;

    // Tick events as (cycles after reset release, {ch1,ch0}), hand-derived.
    localparam int N_EXP = 21;
    int         tbl_off  [N_EXP] = '{4, 8, 11, 12, 16, 17, 18, 19, 20, 21, 24,
                                     25, 28, 29, 37, 38, 44, 46, 48, 56, 60};
    logic [1:0] tbl_mask [N_EXP] = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01,
                                     2'b01, 2'b01, 2'b11, 2'b01, 2'b10, 2'b01,
                                     2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10,
                                     2'b01, 2'b11, 2'b11};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL tick_missing: no event seen, required mask %b at cycle %0d",
                         exp_q[0].mask, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (tick !== e.mask) begin
                    errors++;
                    $display("FAIL tick_event: cycle %0d got %b required %b", cyc, tick, e.mask);
                end
            end else if (tick !== 2'b00) begin
                checks++;
                errors++;
                $display("FAIL tick_unexpected: cycle %0d got %b required 00", cyc, tick);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, req);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = 8'd0;
        cfg3_valid = 1'b0; cfg3_ch = 2'd0; cfg3_div = 8'd0;

        goto(3);
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_pend", 32'(pend), 32'h0);
        chk("reset_ready", 32'(cfg_ready), 32'h1);
        reset = 1'b0;
        en    = 1'b1;
        base  = cyc;
        for (int k = 0; k < N_EXP; k++) begin
            exp_t e;
            e.cyc  = base + tbl_off[k];
            e.mask = tbl_mask[k];
            exp_q.push_back(e);
        end
        mon_on = 1'b1;

        // Out-of-range channel on a 3-channel instance: accepted, no effect.
        goto(base + 1);
        cfg3_valid = 1'b1; cfg3_ch = 2'd3; cfg3_div = 8'd2;
        #1 chk("oor_ready", 32'(cfg3_ready), 32'h1);
        goto(base + 2);
        cfg3_valid = 1'b0;
        chk("oor_pend", 32'(pend3), 32'h0);
        goto(base + 4);
        chk("oor_tick_hi", 32'(tick3), 32'h7);
        goto(base + 5);
        chk("oor_tick_lo", 32'(tick3), 32'h0);

        goto(base + 6);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd3;
        #1 chk("wr_ch0_ready", 32'(cfg_ready), 32'h1);
        goto(base + 7);
        chk("pend_after_wr", 32'(pend), 32'h1);
        cfg_valid = 1'b0; cfg_ch = 1'b1;
        #1 chk("ready_other_ch", 32'(cfg_ready), 32'h1);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd5;
        #1 chk("stall_ready", 32'(cfg_ready), 32'h0);
        goto(base + 8);
        chk("pend_applied", 32'(pend), 32'h0);
        chk("ready_after_apply", 32'(cfg_ready), 32'h1);
        goto(base + 9);
        cfg_valid = 1'b0;
        chk("pend_second_wr", 32'(pend), 32'h1);
        goto(base + 11);
        chk("pend_second_apply", 32'(pend), 32'h0);

        goto(base + 12);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd0;
        goto(base + 13);
        cfg_valid = 1'b0;
        chk("pend_div0", 32'(pend), 32'h1);
        goto(base + 16);
        chk("pend_div0_apply", 32'(pend), 32'h0);

        // Accepted on a wrap edge: must survive that wrap.
        goto(base + 19);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd4;
        goto(base + 20);
        cfg_valid = 1'b0;
        chk("pend_same_edge", 32'(pend), 32'h1);
        goto(base + 21);
        chk("pend_next_wrap", 32'(pend), 32'h0);

        goto(base + 30);
        en = 1'b0;
        goto(base + 35);
        en = 1'b1;

        goto(base + 38);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd6;
        goto(base + 39);
        cfg_valid = 1'b0;
        chk("pend_ch1", 32'(pend), 32'h2);
        cfg_ch = 1'b0;
        sync   = 1'b1;
        #1 chk("sync_ready", 32'(cfg_ready), 32'h0);
        goto(base + 40);
        sync = 1'b0;
        chk("sync_applied", 32'(pend), 32'h0);

        goto(base + 49);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd2;
        goto(base + 50);
        cfg_valid = 1'b0;
        chk("pend_before_reset", 32'(pend), 32'h2);
        reset = 1'b1;
        goto(base + 52);
        reset = 1'b0;
        chk("reset_mid_pend", 32'(pend), 32'h0);
        chk("reset_mid_tick", 32'(tick), 32'h0);

        goto(base + 62);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
